regdump_reader: RTL and testbench

Debug-port initiator for the 32×32 CPU register file: on a start pulse it walks a register index range over the file's debug read port (address, debug clock, debug data), captures each word, and streams it out over a valid/ready handshake to a host-side consumer such as a UART or display driver. It sits beside the register file and owns that file's debug address and debug clock inputs; the CPU datapath ports are untouched.

---
 rtl/regdump_pkg.sv | 19 +
 rtl/regdump_reader_if.sv | 28 ++
 rtl/regdump_reader.sv | 169 ++++++++++++++++
 tb/tb_regdump_reader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and sizes for the register-file dump initiator.
// The CSUM state exists only when REGDUMP_CHECKSUM_EN is defined.
package regdump_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_W    = 32;
  localparam int IDX_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_FALL,
    ST_SEND
`ifdef REGDUMP_CHECKSUM_EN
    , ST_CSUM
`endif
  } state_e;

endpackage

// File: rtl/regdump_reader_if.sv
// regdump_reader_if: host-side word stream (valid/ready) carrying dumped
// register words, their index and the end-of-dump marker.
interface regdump_reader_if;
  import regdump_pkg::*;

  logic [REG_W-1:0] out_data;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regdump_reader.sv
// regdump_reader: on start, walks FIRST_REG..LAST_REG over the register file's
// debug read port (address + registered debug clock, falling-edge sampled)
// and streams each word to the host with a valid/ready handshake.
// Build macro REGDUMP_CHECKSUM_EN adds a trailing XOR checksum word
// (out_idx=0) which then carries out_last instead of the LAST_REG word.
module regdump_reader
  import regdump_pkg::*;
#(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  output logic [IDX_W-1:0] dbg_radd,
  output logic             dbg_clk,
  input  logic [REG_W-1:0] dbg_rdata,
  regdump_reader_if.master stream,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dbg_clk_q, dbg_clk_d;
  logic [REG_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer;
`ifdef REGDUMP_CHECKSUM_EN
  logic [REG_W-1:0] csum_q, csum_d;
`endif

  // Every output comes straight from a flop; idx doubles as the debug address.
  assign dbg_radd         = idx_q;
  assign dbg_clk          = dbg_clk_q;
  assign stream.out_data  = out_data_q;
  assign stream.out_idx   = out_idx_q;
  assign stream.out_valid = out_valid_q;
  assign stream.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;

  // Next-state and next-output logic; registered values hold unless changed.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dbg_clk_d   = dbg_clk_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    xfer        = out_valid_q && stream.out_ready;
`ifdef REGDUMP_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SET;
          idx_d     = FIRST_IDX;
          dbg_clk_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_SET: begin
        dbg_clk_d = 1'b0;
        state_d   = ST_FALL;
      end
      ST_FALL: begin
        out_data_d  = dbg_rdata;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
`ifdef REGDUMP_CHECKSUM_EN
          csum_d = csum_q ^ out_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            state_d    = ST_CSUM;
            out_data_d = csum_q ^ out_data_q;
            out_idx_d  = '0;
            out_last_d = 1'b1;
`else
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
`endif
          end else begin
            state_d     = ST_SET;
            idx_d       = idx_q + 1'b1;
            dbg_clk_d   = 1'b1;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (xfer) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
        end
      end
`endif
      default: begin
        state_d     = ST_IDLE;
        dbg_clk_d   = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any dump immediately.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dbg_clk_q   <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dbg_clk_q   <= dbg_clk_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGDUMP_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_regdump_reader.sv
// tb_regdump_reader: two readers (full range 0..31 and single register 5)
// fed by behavioural register files; expected words go into per-reader
// queues and a monitor pops and compares on each handshake transfer.
// Honors REGDUMP_CHECKSUM_EN for the trailing checksum word.
`timescale 1ns/1ps
module tb_regdump_reader;
  import regdump_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
  } word_t;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CSUM_EXTRA = 1;
`else
  localparam int CSUM_EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [1:0]  start_v = 2'b00;
  logic [4:0]  dbg_radd_a, dbg_radd_b;
  logic        dbg_clk_a, dbg_clk_b;
  logic [31:0] dbg_rdata_a = '0;
  logic [31:0] dbg_rdata_b = '0;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int done_cnt [2];
  int last_xfer [2];
  int exp_done [2];
  word_t q_a[$];
  word_t q_b[$];

  regdump_reader_if bus_a ();
  regdump_reader_if bus_b ();

  regdump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut_a (
    .clk(clk), .res_n(res_n), .start(start_v[0]),
    .dbg_radd(dbg_radd_a), .dbg_clk(dbg_clk_a), .dbg_rdata(dbg_rdata_a),
    .stream(bus_a), .busy(busy_a), .done(done_a)
  );

  regdump_reader #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
    .clk(clk), .res_n(res_n), .start(start_v[1]),
    .dbg_radd(dbg_radd_b), .dbg_clk(dbg_clk_b), .dbg_rdata(dbg_rdata_b),
    .stream(bus_b), .busy(busy_b), .done(done_b)
  );

  logic [1:0]  m_valid, m_ready, m_last, m_done, m_busy, m_dclk;
  logic [31:0] m_data [2];
  logic [4:0]  m_idx [2];
  logic [4:0]  m_radd [2];
  assign m_valid   = {bus_b.out_valid, bus_a.out_valid};
  assign m_ready   = {bus_b.out_ready, bus_a.out_ready};
  assign m_last    = {bus_b.out_last, bus_a.out_last};
  assign m_done    = {done_b, done_a};
  assign m_busy    = {busy_b, busy_a};
  assign m_dclk    = {dbg_clk_b, dbg_clk_a};
  assign m_data[0] = bus_a.out_data;
  assign m_data[1] = bus_b.out_data;
  assign m_idx[0]  = bus_a.out_idx;
  assign m_idx[1]  = bus_b.out_idx;
  assign m_radd[0] = dbg_radd_a;
  assign m_radd[1] = dbg_radd_b;

  // System clock, 10 ns period.
  always #5 clk = ~clk;

  // Register file A latches its debug read word on the falling debug clock.
  always @(negedge dbg_clk_a) dbg_rdata_a <= regs_a[dbg_radd_a];

  // Register file B latches its debug read word on the falling debug clock.
  always @(negedge dbg_clk_b) dbg_rdata_b <= regs_b[dbg_radd_b];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void pushExp(input int s, input word_t w);
    if (s == 0) q_a.push_back(w);
    else q_b.push_back(w);
  endfunction

  function automatic word_t popExp(input int s);
    if (s == 0) return q_a.pop_front();
    return q_b.pop_front();
  endfunction

  function automatic int sizeExp(input int s);
    return (s == 0) ? q_a.size() : q_b.size();
  endfunction

  task automatic pushDump(input int s, input int first, input int last, input logic [31:0] csum);
    word_t w;
    for (int i = first; i <= last; i++) begin
      w.data = (s == 0) ? regs_a[i] : regs_b[i];
      w.idx  = 5'(i);
`ifdef REGDUMP_CHECKSUM_EN
      w.last = 1'b0;
`else
      w.last = (i == last);
`endif
      pushExp(s, w);
    end
    w.data = csum;
    w.idx  = 5'd0;
    w.last = 1'b1;
    if (CSUM_EXTRA != 0) pushExp(s, w);
  endtask

  task automatic monitor(input int s);
    word_t cur, prev;
    bit prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!res_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{data: m_data[s], idx: m_idx[s], last: m_last[s]};
        if (prev_stall)
          checkOutput($sformatf("dut%0d_stall_hold", s), {25'd0, m_valid[s], cur}, {25'd0, 1'b1, prev});
        if (m_valid[s] && m_ready[s]) begin
          if (sizeExp(s) == 0) checkOutput($sformatf("dut%0d_unexpected_word", s), 64'(cur), 64'(1'b0));
          else checkOutput($sformatf("dut%0d_word", s), 64'(cur), 64'(popExp(s)));
          last_xfer[s] = cyc + 1;
        end
        if (m_done[s]) begin
          done_cnt[s]++;
          checkOutput($sformatf("dut%0d_done_after_xfer", s), 64'(cyc), 64'(last_xfer[s]));
          checkOutput($sformatf("dut%0d_busy_at_done", s), 64'(m_busy[s]), 64'(1'b0));
          if (exp_done[s] >= 0)
            checkOutput($sformatf("dut%0d_done_cycle", s), 64'(cyc), 64'(exp_done[s]));
        end
        prev_stall = m_valid[s] && !m_ready[s];
        prev = cur;
      end
    end
  endtask

  task automatic applyStimulus(input int s, input int first, input int last,
                               input logic [31:0] csum, input bit timed);
    int kcyc;
    pushDump(s, first, last, csum);
    @(posedge clk);
    #1;
    start_v[s] = 1'b1;
    kcyc = cyc + 1;
    exp_done[s] = timed ? kcyc + 3 * (last - first + 1) + CSUM_EXTRA : -1;
    @(posedge clk);
    @(negedge clk);
    checkOutput($sformatf("dut%0d_dbg_clk_rise", s), 64'(m_dclk[s]), 64'(1'b1));
    checkOutput($sformatf("dut%0d_dbg_radd_first", s), 64'(m_radd[s]), 64'(first));
    checkOutput($sformatf("dut%0d_busy_start", s), 64'(m_busy[s]), 64'(1'b1));
    start_v[s] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("dut%0d_dbg_clk_fall", s), 64'(m_dclk[s]), 64'(1'b0));
    checkOutput($sformatf("dut%0d_valid_early", s), 64'(m_valid[s]), 64'(1'b0));
    @(negedge clk);
    checkOutput($sformatf("dut%0d_valid_k2", s), 64'(m_valid[s]), 64'(1'b1));
    checkOutput($sformatf("dut%0d_first_idx", s), 64'(m_idx[s]), 64'(first));
  endtask

  task automatic waitDone(input int s, input int prev, input int budget);
    int n = 0;
    while (done_cnt[s] == prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt[s] == prev) checkOutput($sformatf("dut%0d_done_timeout", s), 64'd0, 64'd1);
    repeat (8) @(negedge clk);
    checkOutput($sformatf("dut%0d_done_count", s), 64'(done_cnt[s]), 64'(prev + 1));
    checkOutput($sformatf("dut%0d_queue_empty", s), 64'(sizeExp(s)), 64'd0);
  endtask

  task automatic waitIdx(input int s, input int idx, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(m_valid[s] && m_idx[s] == 5'(idx)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(m_valid[s] && m_idx[s] == 5'(idx)))
      checkOutput($sformatf("dut%0d_idx%0d_timeout", s, idx), 64'd0, 64'd1);
  endtask

  initial begin
    int prev;
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = '0;
      regs_b[i] = '0;
    end
    regs_a[28] = 32'h1000_8000;
    regs_a[29] = 32'h0000_00FF;
    regs_b[5]  = 32'hDEAD_BEEF;
    for (int s = 0; s < 2; s++) begin
      done_cnt[s] = 0;
      last_xfer[s] = -1;
      exp_done[s] = -1;
    end
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(posedge clk);
        #1;
        bus_a.out_ready = (ready_mode == 0) || (cyc % 3 == 0);
      end
      monitor(0);
      monitor(1);
      begin
        #50000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    // Reset values while res_n is held low.
    #12;
    checkOutput("rst_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("rst_data", 64'(bus_a.out_data), 64'd0);
    checkOutput("rst_idx", 64'(bus_a.out_idx), 64'd0);
    checkOutput("rst_last", 64'(bus_a.out_last), 64'd0);
    checkOutput("rst_busy_done", {62'd0, busy_a, done_a}, 64'd0);
    checkOutput("rst_dbg", {58'd0, dbg_clk_a, dbg_radd_a}, 64'd0);
    @(negedge clk);
    #2 res_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] full-rate dump 0..31");
    prev = done_cnt[0];
    applyStimulus(0, 0, 31, 32'h1000_80FF, 1'b1);
    waitDone(0, prev, 400);

    $display("[TB] stalled dump, ready 1-of-3");
    ready_mode = 1;
    prev = done_cnt[0];
    applyStimulus(0, 0, 31, 32'h1000_80FF, 1'b0);
    waitDone(0, prev, 600);
    ready_mode = 0;

    $display("[TB] single-register dump r5");
    prev = done_cnt[1];
    applyStimulus(1, 5, 5, 32'hDEAD_BEEF, 1'b1);
    waitDone(1, prev, 50);

    $display("[TB] start pulsed mid-dump at idx 10");
    prev = done_cnt[0];
    applyStimulus(0, 0, 31, 32'h1000_80FF, 1'b1);
    waitIdx(0, 10, 100);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    waitDone(0, prev, 400);
    checkOutput("midstart_idle_busy", 64'(busy_a), 64'd0);

    $display("[TB] reset during SEND at idx 7");
    prev = done_cnt[0];
    applyStimulus(0, 0, 31, 32'h1000_80FF, 1'b1);
    waitIdx(0, 7, 100);
    #2 res_n = 1'b0;
    #1;
    checkOutput("abort_valid", 64'(bus_a.out_valid), 64'd0);
    checkOutput("abort_data", 64'(bus_a.out_data), 64'd0);
    checkOutput("abort_idx_last", {58'd0, bus_a.out_idx, bus_a.out_last}, 64'd0);
    checkOutput("abort_busy_done", {62'd0, busy_a, done_a}, 64'd0);
    checkOutput("abort_dbg", {58'd0, dbg_clk_a, dbg_radd_a}, 64'd0);
    q_a.delete();
    exp_done[0] = -1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 64'(done_cnt[0]), 64'(prev));
    #2 res_n = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(0, 0, 31, 32'h1000_80FF, 1'b1);
    waitDone(0, prev, 400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
